// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine holding architectural HI/LO; results land n+1 cycles after start.
// start and MTHI/MTLO writes are accepted only in IDLE; while busy they are dropped, never queued.
module mul_div_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] HI,
  output logic [n-1:0] LO
);

  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*n-1:0] acc_q, acc_d;
  logic [n-1:0]   opnd_q, opnd_d;
  logic [n-1:0]   dvd_q, dvd_d;
  logic [n-1:0]   hi_q, hi_d;
  logic [n-1:0]   lo_q, lo_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic           div0_q, div0_d;

  logic [n-1:0]   a_mag, b_mag;
  logic [n:0]     msum, rem_sh, trial;
  logic [2*n-1:0] prod;
  logic [n-1:0]   quot, rem;

  // op[0] marks the signed variants; the engine itself always works on magnitudes.
  assign a_mag  = (op[0] && A[n-1]) ? -A : A;
  assign b_mag  = (op[0] && B[n-1]) ? -B : B;

  assign msum   = {1'b0, acc_q[2*n-1:n]} + {1'b0, opnd_q};
  // The bit shifted out of rem must take part in the compare, hence the n+1-bit window.
  assign rem_sh = acc_q[2*n-1:n-1];
  assign trial  = rem_sh - {1'b0, opnd_q};

  assign prod   = neg_q  ? -acc_q          : acc_q;
  assign quot   = neg_q  ? -acc_q[n-1:0]   : acc_q[n-1:0];
  assign rem    = rneg_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    dvd_d    = dvd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_d    = op[0] & (A[n-1] ^ B[n-1]);
          rneg_d   = op[0] & A[n-1];
          div0_d   = (B == '0);
          dvd_d    = A;
          cnt_d    = '0;
          if (op[1]) begin
            acc_d  = {{n{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{n{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          state_d  = CALC;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      CALC: begin
        if (!is_div_q) begin
          acc_d = acc_q[0] ? {msum, acc_q[n-1:1]} : {1'b0, acc_q[2*n-1:1]};
        end else if (trial[n]) begin
          acc_d = {rem_sh[n-1:0], acc_q[n-2:0], 1'b0};
        end else begin
          acc_d = {trial[n-1:0], acc_q[n-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(n-1)) state_d = FIX;
      end

      FIX: begin
        if (!is_div_q) begin
          hi_d = prod[2*n-1:n];
          lo_d = prod[n-1:0];
        end else if (div0_q) begin
          // Divide by zero: all-ones quotient, dividend passed through as remainder.
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      dvd_q    <= dvd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide engine for the MIPS datapath; the iterative counterpart to the single-cycle add/sub/slt arithmetic unit.
- Executes MULT, MULTU, DIV and DIVU over n cycles using shift-add or restoring shift-subtract.
- Holds results in architectural HI/LO registers read by MFHI/MFLO.
- Uses a start/busy/done handshake; the control unit stalls on busy.

Parameters:
n, 32, operand and HI/LO width; must be ≥ 4.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV; sampled with start
A  input  n  multiplicand / dividend (rs)
B  input  n  multiplier / divisor (rt)
hi_we  input  1  MTHI write; honoured only in IDLE with start=0
lo_we  input  1  MTLO write; honoured only in IDLE with start=0
wdata  input  n  MTHI/MTLO data
busy  output  1  high from start acceptance until done
done  output  1  one-cycle completion pulse
HI  output  n  HI register (product high half / remainder)
LO  output  n  LO register (product low half / quotient)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, HI=0, LO=0, iteration counter=0, internal operand regs=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge k: latch op; latch |A| and |B| when op is signed, raw values otherwise; record result signs; clear partial accumulator; counter=0; go CALC; busy=1 from edge k.
  - hi_we/lo_we load HI/LO from wdata. Both may assert together.
  - start has priority: if start=1, hi_we/lo_we are ignored.
- CALC: one iteration per edge for n edges (k+1..k+n).
  - Multiply: if multiplier LSB is set, add multiplicand into the upper half of a 2n-bit accumulator, carry included; then shift right by 1.
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor from rem using an (n+1)-bit subtract. If non-negative, keep it and set quot LSB=1.
  - Counter increments each edge; at counter=n-1 go FIX.
- FIX (edge k+n+1): apply sign correction and write HI/LO; go DONE; done=1, busy=0.
  - MULT: negate the 2n-bit product when the operand signs differ.
  - DIV: quotient negated when signs differ; remainder takes the dividend's sign.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE, done=0.
- Latency and validity: start sampled at edge k gives HI/LO valid from edge k+n+1. HI/LO keep their old values while busy.
- start while busy (CALC/FIX/DONE): ignored, no queuing. hi_we/lo_we while busy: ignored.
- Divide by zero (no trap), identical latency:
  - DIVU: LO = all ones, HI = A.
  - DIV: LO = all ones, HI = A.
- Signed overflow, DIV with A = -2^(n-1) and B = -1: LO = 2^(n-1) (0x80000000 at n=32), HI = 0.
- Reset mid-operation: abort immediately; all outputs return to reset values; no partial result is written.
- All arithmetic is modulo 2^n per register; no overflow flag.

Test Plan:
- MULTU A=59, B=77 -> done exactly 33 clocks after start sampled; HI=0, LO=4543; busy high for 33 cycles.
- DIVU A=528, B=456 -> LO=1, HI=72. Then DIV A=-552 (0xFFFFFDD8), B=105 -> LO=0xFFFFFFFB (-5), HI=0xFFFFFFE5 (-27).
- MULT A=-3, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=100. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; normal latency.
- Mid-operation interference:
  - While busy, pulse start with different operands plus hi_we=1 (wdata=0x1234) -> first result unaffected, no second done.
  - In IDLE, hi_we=1, wdata=0x1234 -> HI=0x1234.
  - Assert rst_n=0 at CALC cycle 10 -> busy=0, HI=LO=0 immediately.
- Back-to-back: start pulsed on the cycle after done -> accepted; second result correct; done pulses exactly once per operation.
